// File: rtl/adder_tree_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_arb_pkg
// Description : Shared types for the arbitrated adder-tree block: operand
//               width, operand type and the result-register state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package adder_tree_arb_pkg;

    localparam int OPERAND_W = 8;

    typedef logic [OPERAND_W-1:0] operand_t;

    // EMPTY: result register free.  FULL: result register holds an
    // unconsumed result.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Increment an index and wrap it back to zero past LIMIT-1.
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned limit);
        return (idx + 1 >= limit) ? 0 : idx + 1;
    endfunction

endpackage : adder_tree_arb_pkg
`default_nettype wire

// File: rtl/adder_tree4_8.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree4_8
// Description : Combinational two-level adder tree summing four 8-bit
//               operands; the result wraps modulo 256, no carry out.
// Revision    : 1.0  initial release
// ============================================================================
module adder_tree4_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    output logic [7:0] sum
);

    logic [7:0] w_sum_ab;
    logic [7:0] w_sum_cd;

    // Two balanced partial sums, then the final level; every stage truncates
    // to 8 bits so the result is the modulo-256 total.
    always_comb begin
        w_sum_ab = a + b;
        w_sum_cd = c + d;
        sum      = w_sum_ab + w_sum_cd;
    end

endmodule : adder_tree4_8
`default_nettype wire

// File: rtl/adder_tree4_8_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker.  Scans the request
//               vector starting at ptr and wrapping modulo NREQ; returns the
//               first hit as a one-hot grant and as an encoded index.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    // One extra bit so ptr + offset never overflows before the wrap test.
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest hit to ptr is the
    // last one written and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_pos     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (IDW+1)'(k);
            if (w_pos >= NREQ_W) begin
                w_pos = w_pos - NREQ_W;
            end
            if (req[w_pos[IDW-1:0]]) begin
                grant                   = '0;
                grant[w_pos[IDW-1:0]]   = 1'b1;
                grant_idx               = w_pos[IDW-1:0];
            end
        end
    end

    assign grant_any = |req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder_tree4_8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree4_8_arbiter
// Description : Shares one adder_tree4_8 among NREQ requesters.  A round-robin
//               arbiter picks one requester per cycle, its four operands are
//               summed, and the 8-bit result is registered together with the
//               requester index on a single valid/ready result port.
// Revision    : 1.0  initial release
// ============================================================================
module adder_tree4_8_arbiter
    import adder_tree_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*8-1:0]     req_a,
    input  logic [NREQ*8-1:0]     req_b,
    input  logic [NREQ*8-1:0]     req_c,
    input  logic [NREQ*8-1:0]     req_d,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [7:0]            res_sum,
    output logic [IDW-1:0]        res_id
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    arb_state_e     state_q,   state_d;
    logic [IDW-1:0] ptr_q,     ptr_d;
    operand_t       res_sum_q, res_sum_d;
    logic [IDW-1:0] res_id_q,  res_id_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic            w_grant_any;
    logic            w_can_accept;
    logic            w_transfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // The result register can take a new value when it is free, or when the
    // current value is being drained this same cycle.  Grants are suppressed
    // during reset so nothing presented alongside rst is accepted.
    always_comb begin
        w_can_accept = (state_q == EMPTY) || res_ready;
        w_transfer   = w_grant_any && w_can_accept && !rst;
        req_ready    = w_transfer ? w_grant : '0;
    end

    // ------------------------------------------------------------------------
    // Operand mux feeding the shared tree
    // ------------------------------------------------------------------------
    operand_t w_op_a, w_op_b, w_op_c, w_op_d;
    operand_t w_tree_sum;

    // Select the granted requester's operand lanes.
    always_comb begin
        w_op_a = req_a[w_grant_idx*OPERAND_W +: OPERAND_W];
        w_op_b = req_b[w_grant_idx*OPERAND_W +: OPERAND_W];
        w_op_c = req_c[w_grant_idx*OPERAND_W +: OPERAND_W];
        w_op_d = req_d[w_grant_idx*OPERAND_W +: OPERAND_W];
    end

    adder_tree4_8 u_adder_tree4_8 (
        .a   (w_op_a),
        .b   (w_op_b),
        .c   (w_op_c),
        .d   (w_op_d),
        .sum (w_tree_sum)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // A transfer always loads the register (covering drain-and-reload with no
    // bubble) and moves ptr past the winner; otherwise a drain empties it.
    // ptr only moves on a transfer, so idle cycles keep the rotation position.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;
        if (w_transfer) begin
            state_d   = FULL;
            res_sum_d = w_tree_sum;
            res_id_d  = w_grant_idx;
            ptr_d     = IDW'(wrap_inc(32'(w_grant_idx), NREQ));
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    // Register update with synchronous reset discarding any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            ptr_q     <= '0;
            res_sum_q <= '0;
            res_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;

endmodule : adder_tree4_8_arbiter
`default_nettype wire

// File: tb/tb_adder_tree4_8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_tree4_8_arbiter
// Description : Directed self-checking bench for adder_tree4_8_arbiter with
//               hand-computed expected sums, ids and grant vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adder_tree4_8_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a, req_b, req_c, req_d;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_sum;
    logic [IDW-1:0]    res_id;

    int n_checks;
    int n_errors;

    adder_tree4_8_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
        req_d[i*8 +: 8] = d;
        req_valid[i]    = 1'b1;
    endtask

    task automatic check_res(input string tag, input logic [7:0] sum,
                             input logic [IDW-1:0] id);
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"},   32'(res_sum),   32'(sum));
        check({tag, "_id"},    32'(res_id),    32'(id));
    endtask

    // Requesters must keep valid up until their transfer.
    logic [NREQ-1:0] pend_q;
    initial pend_q = '0;
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (pend_q[i] && !rst) check("valid_hold", 32'(req_valid[i]), 32'd1);
        end
        pend_q <= rst ? '0 : (req_valid & ~req_ready);
    end

    logic [NREQ-1:0] rdy_snap;
    logic [7:0]      exp3 [NREQ];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        res_ready = 1'b1;

        // Reset, with a request presented during reset that must not be taken.
        step();
        set_req(0, 8'd1, 8'd1, 8'd1, 8'd1);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        step();
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_sum",   32'(res_sum),   32'd0);
        check("rst_id",    32'(res_id),    32'd0);
        rst = 1'b0;
        req_valid = '0;
        step();
        check("idle_valid", 32'(res_valid), 32'd0);

        // 1: single request.
        set_req(0, 8'd4, 8'd5, 8'd11, 8'd9);
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        check_res("t1", 8'd29, 2'd0);
        check("t1_ready_off", 32'(req_ready), 32'd0);
        step();
        check("t1_drain", 32'(res_valid), 32'd0);

        // 2: wrap-around arithmetic on requester 2 (ptr=1 scans 1,2).
        set_req(2, 8'd15, 8'd3, 8'd200, 8'd7);
        #1;
        check("t2_ready0", 32'(req_ready), 32'b0100);
        step();
        set_req(2, 8'd200, 8'd100, 8'd0, 8'd1);
        #1;
        check_res("t2a", 8'd225, 2'd2);
        check("t2_ready1", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        #1;
        check_res("t2b", 8'd45, 2'd2);
        step();
        check("t2_drain", 32'(res_valid), 32'd0);

        // 3: round robin from ptr=0 (reset first), all four requesting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp3[0] = 8'd111; exp3[1] = 8'd123; exp3[2] = 8'd135; exp3[3] = 8'd147;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 8'(i + 1), 8'(10 * (i + 1)), 8'd100, 8'(i));
        end
        #1;
        for (int n = 0; n < 8; n++) begin
            check("t3_grant", 32'(req_ready), 32'(1 << (n % 4)));
            rdy_snap = req_ready;
            step();
            if (n >= 4) req_valid = req_valid & ~rdy_snap;
            #1;
            check_res("t3", exp3[n % 4], IDW'(n % 4));
        end
        step();
        check("t3_drain", 32'(res_valid), 32'd0);

        // 4: backpressure with requesters 1 and 3 (ptr=0).
        set_req(1, 8'd1, 8'd2, 8'd3, 8'd4);
        set_req(3, 8'd10, 8'd20, 8'd30, 8'd40);
        #1;
        check("t4_grant1", 32'(req_ready), 32'b0010);
        step();
        req_valid[1] = 1'b0;
        res_ready    = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_res("t4_hold", 8'd10, 2'd1);
            check("t4_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("t4_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid[3] = 1'b0;
        #1;
        check_res("t4_next", 8'd100, 2'd3);
        step();
        check("t4_drain", 32'(res_valid), 32'd0);

        // 5: pointer retention across idle cycles (ptr=0).
        set_req(1, 8'd7, 8'd7, 8'd7, 8'd7);
        #1;
        check("t5_grant1", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        #1;
        check_res("t5a", 8'd28, 2'd1);
        for (int k = 0; k < 5; k++) step();
        check("t5_idle", 32'(res_valid), 32'd0);
        set_req(0, 8'd1, 8'd1, 8'd1, 8'd1);
        set_req(2, 8'd2, 8'd2, 8'd2, 8'd2);
        #1;
        check("t5_grant2", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        #1;
        check_res("t5b", 8'd8, 2'd2);
        check("t5_grant0", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        #1;
        check_res("t5c", 8'd4, 2'd0);
        step();

        // 6: reset while FULL under backpressure with requests pending (ptr=1).
        res_ready = 1'b0;
        set_req(0, 8'd9, 8'd9, 8'd9, 8'd9);
        set_req(1, 8'd3, 8'd3, 8'd3, 8'd3);
        #1;
        check("t6_grant1", 32'(req_ready), 32'b0010);
        step();
        req_valid[1] = 1'b0;
        #1;
        check_res("t6_full", 8'd12, 2'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        step();
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_sum",   32'(res_sum),   32'd0);
        check("t6_id",    32'(res_id),    32'd0);
        rst       = 1'b0;
        res_ready = 1'b1;
        set_req(3, 8'd1, 8'd2, 8'd3, 8'd4);
        #1;
        check("t6_grant0", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        #1;
        check_res("t6a", 8'd36, 2'd0);
        check("t6_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid[3] = 1'b0;
        #1;
        check_res("t6b", 8'd10, 2'd3);
        step();
        check("t6_drain", 32'(res_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_adder_tree4_8_arbiter
`default_nettype wire

// File: doc/adder_tree4_8_arbiter.md
Name: adder_tree4_8_arbiter

Overview:
Shares one combinational adder_tree4_8 instance among NREQ requesters. Each requester presents four 8-bit operands with a valid/ready handshake. A round-robin arbiter grants one requester per cycle and feeds its operands to the tree. The 8-bit sum is registered, tagged with the requester index, and sent to a single valid/ready result port. The block sits between multiple client datapaths and the shared adder resource.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), derived width of the requester index; not overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  NREQ  bit i is set when requester i has operands pending.
req_ready  output  NREQ  one-hot or zero; bit i is the grant to requester i this cycle.
req_a  input  NREQ*8  operand a; requester i drives bits [8i+7:8i].
req_b  input  NREQ*8  operand b, packed as req_a.
req_c  input  NREQ*8  operand c, packed as req_a.
req_d  input  NREQ*8  operand d, packed as req_a.
res_valid  output  1  result register holds a valid result.
res_ready  input  1  downstream accepts the result this cycle.
res_sum  output  8  (a+b+c+d) mod 256 for the granted request.
res_id  output  IDW  index of the requester that produced res_sum.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: res_valid=0, res_sum=0, res_id=0, round-robin pointer ptr=0, FSM=EMPTY. req_ready is combinational and is 0 whenever rst=1.
- FSM states: EMPTY (result register free) and FULL (result register holds an unconsumed result).
- can_accept = (state==EMPTY) or (state==FULL and res_ready).
- Grant rule: if can_accept and any req_valid is set, grant g is the first set bit of req_valid found by scanning from ptr upward, modulo NREQ.
- Grant outputs: req_ready[g]=1 and all other bits are 0. req_ready never asserts without can_accept.
- Handshake: a transfer occurs when req_valid[g] and req_ready[g] are both 1.
- Requester rules: a requester holds valid and operands stable until its transfer. Withdrawing valid before the transfer is not allowed; the bench asserts this.
- On transfer: res_sum <= tree sum of req_*[g] and res_id <= g on the next edge. State becomes FULL and ptr <= (g+1) mod NREQ.
- Latency: exactly 1 cycle from transfer to res_valid=1.
- Throughput: 1 result per cycle while res_ready is held at 1.
- FULL with res_ready=0: res_valid, res_sum and res_id hold stable; no grants are issued.
- FULL with res_ready=1 and no new grant: state becomes EMPTY and res_valid deasserts next cycle.
- Simultaneous drain and grant in FULL: the register reloads with the new result and res_valid stays 1 with no bubble.
- Idle cycles: ptr updates only on a transfer and is never advanced by idle cycles.
- Fairness: a continuously requesting requester is granted within NREQ transfers.
- Arithmetic: the sum is 8-bit and wraps modulo 256, matching adder_tree4_8. No carry or overflow is reported.
- Reset mid-operation: a pending result is discarded and res_valid=0 next cycle. A request presented in the same cycle as rst is not accepted.
- req_ready depends combinationally on req_valid, res_ready, state and ptr. Downstream must not derive res_ready combinationally from req_ready.

Decomposition:
- Package adder_tree_arb_pkg:
  - OPERAND_W=8;
  - typedef operand_t logic[7:0];
  - enum arb_state_e {EMPTY, FULL}.
- Sub-modules:
  - Reuse the existing adder_tree4_8 unchanged as the shared datapath, fed by a mux indexed by the grant.
  - One new sub-module, rr_arbiter, is natural: NREQ request vector and ptr in, one-hot grant and encoded index out. It is purely combinational; ptr stays in the parent.

Test Plan:
1. Single request, no contention:
   - Stimulus: after reset, req 0 presents a=4, b=5, c=11, d=9 with res_ready=1.
   - Required: req_ready[0] high the same cycle; next cycle res_valid=1, res_sum=29, res_id=0; then res_valid=0.
2. Wrap-around arithmetic:
   - Stimulus: req 2 presents a=15, b=3, c=200, d=7, then a=200, b=100, c=0, d=1.
   - Required: res_sum=225, then res_sum=45 (301 mod 256); res_id=2 both times.
3. Round-robin fairness:
   - Stimulus: all four requesters valid every cycle, each with distinct operands, res_ready=1.
   - Required: res_id sequence 0,1,2,3,0,1 with one result per cycle and sums correct per requester.
4. Backpressure:
   - Stimulus: req 1 and req 3 valid; res_ready=0 for 3 cycles after the first result.
   - Required: res_sum and res_id stay stable for those cycles; req_ready is all zero.
   - Required after res_ready rises: next grant goes to requester 3 with no bubble (drain and load in the same cycle).
5. Pointer retention:
   - Stimulus: grant requester 1; idle for 5 cycles; then requesters 0 and 2 valid together.
   - Required: requester 2 is granted first, then requester 0.
6. Reset mid-operation:
   - Stimulus: assert rst while FULL with res_ready=0 and requests pending.
   - Required: next cycle res_valid=0, res_sum=0, res_id=0.
   - Required after rst is released: first grant goes to the lowest-indexed valid requester (ptr=0).
